// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the microPC, selects the next microaddress,
// gates the datapath control word and tracks retirements and sticky error flags.
module micro_sequencer #(
  parameter int UADDR_W    = 4,
  parameter int UIR_W      = 15,
  parameter int OP_W       = 6,
  parameter int UROM_DEPTH = 10,
  parameter int FETCH_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [UIR_W-1:0]   MicroIR,
  input  logic [OP_W-1:0]    OpCode,
  input  logic               Stall,
  output logic [UADDR_W-1:0] AddrOut,
  output logic [UIR_W-1:0]   CtrlOut,
  output logic               IllegalOp,
  output logic               BadUAddr,
  output logic [CNT_W-1:0]   InstrCount
);

  typedef enum logic [1:0] {
    SEQ_NEXT  = 2'b00,
    SEQ_DISP1 = 2'b01,
    SEQ_DISP2 = 2'b10,
    SEQ_FETCH = 2'b11
  } seq_ctl_e;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [UADDR_W-1:0] FETCH_UA = UADDR_W'(FETCH_ADDR);
  localparam logic [UADDR_W:0]   DEPTH_UA = (UADDR_W + 1)'(UROM_DEPTH);

  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               illegal_op_q, illegal_op_d;
  logic               bad_uaddr_q, bad_uaddr_d;

  seq_ctl_e           seq_ctl;
  logic [UADDR_W-1:0] next_field;
  logic [UADDR_W-1:0] sel_addr;
  logic               dispatch_illegal;
  logic               addr_out_of_range;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    seq_ctl          = seq_ctl_e'(MicroIR[UADDR_W+1:UADDR_W]);
    next_field       = MicroIR[UADDR_W-1:0];
    sel_addr         = FETCH_UA;
    dispatch_illegal = 1'b0;

    unique case (seq_ctl)
      SEQ_NEXT:  sel_addr = next_field;
      SEQ_DISP1: begin
        case (OpCode)
          OP_RTYPE:      sel_addr = UADDR_W'(6);
          OP_LW, OP_SW:  sel_addr = UADDR_W'(2);
          OP_BEQ:        sel_addr = UADDR_W'(8);
          OP_J:          sel_addr = UADDR_W'(9);
          default:       dispatch_illegal = 1'b1;
        endcase
      end
      SEQ_DISP2: begin
        case (OpCode)
          OP_LW:   sel_addr = UADDR_W'(3);
          OP_SW:   sel_addr = UADDR_W'(5);
          default: dispatch_illegal = 1'b1;
        endcase
      end
      SEQ_FETCH: sel_addr = FETCH_UA;
      default:   sel_addr = FETCH_UA;
    endcase

    addr_out_of_range = ({1'b0, sel_addr} >= DEPTH_UA);

    upc_d         = upc_q;
    instr_count_d = instr_count_q;
    illegal_op_d  = illegal_op_q;
    bad_uaddr_d   = bad_uaddr_q;

    // A stall freezes everything, including error capture.
    if (!Stall) begin
      upc_d = addr_out_of_range ? FETCH_UA : sel_addr;
      if (seq_ctl == SEQ_FETCH) instr_count_d = instr_count_q + CNT_W'(1);
      if (dispatch_illegal)     illegal_op_d  = 1'b1;
      if (addr_out_of_range)    bad_uaddr_d   = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      upc_q         <= FETCH_UA;
      instr_count_q <= '0;
      illegal_op_q  <= 1'b0;
      bad_uaddr_q   <= 1'b0;
    end else begin
      upc_q         <= upc_d;
      instr_count_q <= instr_count_d;
      illegal_op_q  <= illegal_op_d;
      bad_uaddr_q   <= bad_uaddr_d;
    end
  end

  assign AddrOut    = upc_q;
  assign CtrlOut    = (Stall || rst) ? '0 : MicroIR;
  assign IllegalOp  = illegal_op_q;
  assign BadUAddr   = bad_uaddr_q;
  assign InstrCount = instr_count_q;

endmodule
